// File: rtl/etherneco_pkg.sv
// Shared types for the EtherNeco sync-timer scheduler.
package etherneco_pkg;

   // Scheduler sequencing states.
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      REQ   = 3'd1,
      START = 3'd2,
      WAIT  = 3'd3,
      GAP   = 3'd4
   } t_sched_state;

   localparam int COUNT_WIDTH_DFLT = 16;

   // Default-width status counter value.
   typedef logic [COUNT_WIDTH_DFLT-1:0] t_count;

endpackage

// File: rtl/etherneco_synctimer_scheduler_if.sv
// Ring-arbiter and synctimer-master command/response signals.
interface etherneco_synctimer_scheduler_if;
   logic ring_req;
   logic ring_grant;
   logic cmd_tx_start;
   logic cmd_tx_override;
   logic cmd_tx_correct;
   logic res_rx_start;
   logic res_rx_end;
   logic res_rx_error;

   // Scheduler side.
   modport master (
      output ring_req, cmd_tx_start, cmd_tx_override, cmd_tx_correct,
      input  ring_grant, res_rx_start, res_rx_end, res_rx_error
   );

   // Arbiter / synctimer-master side.
   modport slave (
      input  ring_req, cmd_tx_start, cmd_tx_override, cmd_tx_correct,
      output ring_grant, res_rx_start, res_rx_end, res_rx_error
   );
endinterface

// File: rtl/etherneco_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module etherneco_sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);
   logic [WIDTH-1:0] count_q, count_d;

   // Next count: clear, or increment until all-ones.
   always_comb begin
      count_d = count_q;
      if (clr)
         count_d = '0;
      else if (inc && (count_q != '1))
         count_d = count_q + WIDTH'(1);
   end

   // Count register.
   always_ff @(posedge clk) begin
      if (reset) count_q <= '0;
      else       count_q <= count_d;
   end

   assign count = count_q;
endmodule

// File: rtl/etherneco_synctimer_scheduler.sv
// Sync-timer sequencer: obtain ring, fire start with override/correct,
// wait for response or timeout, then pace the next cycle by period.
module etherneco_synctimer_scheduler
   import etherneco_pkg::*;
#(
   parameter int PERIOD_WIDTH   = 32,
   parameter int TIMEOUT_WIDTH  = 24,
   parameter int OVERRIDE_COUNT = 2,
   parameter int COUNT_WIDTH    = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     enable,
   input  logic [PERIOD_WIDTH-1:0]  period,
   input  logic [TIMEOUT_WIDTH-1:0] timeout,
   input  logic                     resync_req,
   etherneco_synctimer_scheduler_if.master bus,
   output logic                     busy,
   output logic                     synced,
   output logic [COUNT_WIDTH-1:0]   sync_count,
   output logic [COUNT_WIDTH-1:0]   error_count,
   output logic [COUNT_WIDTH-1:0]   timeout_count
);
   localparam int OW = (OVERRIDE_COUNT < 1) ? 1 : $clog2(OVERRIDE_COUNT + 1);
   localparam logic [OW-1:0] OVR_INIT = OW'(OVERRIDE_COUNT);

   t_sched_state state_q, state_d;
   logic ring_req_q, ring_req_d;
   logic start_q, start_d, ovr_q, ovr_d, cor_q, cor_d;
   logic busy_q, busy_d, synced_q, synced_d;
   logic ovr_cycle_q, ovr_cycle_d;   // current cycle was issued as override
   logic [OW-1:0] ovr_rem_q, ovr_rem_d;

   logic grant_go, good, err, tmo;
   logic [TIMEOUT_WIDTH-1:0] tcnt;
   logic [PERIOD_WIDTH-1:0]  icnt, per_m1;
   logic unused_rx_start;

   // res_rx_start carries no sequencing meaning here.
   assign unused_rx_start = bus.res_rx_start;
   assign per_m1 = (period == '0) ? '0 : period - PERIOD_WIDTH'(1);

   // Counters are cleared on the grant edge so they read 0 in START.
   etherneco_sat_counter #(.WIDTH(TIMEOUT_WIDTH)) u_tcnt (
      .clk(clk), .reset(reset), .clr(grant_go), .inc(1'b1), .count(tcnt));
   etherneco_sat_counter #(.WIDTH(PERIOD_WIDTH)) u_icnt (
      .clk(clk), .reset(reset), .clr(grant_go), .inc(1'b1), .count(icnt));
   etherneco_sat_counter #(.WIDTH(COUNT_WIDTH)) u_sync_cnt (
      .clk(clk), .reset(reset), .clr(1'b0), .inc(good), .count(sync_count));
   etherneco_sat_counter #(.WIDTH(COUNT_WIDTH)) u_err_cnt (
      .clk(clk), .reset(reset), .clr(1'b0), .inc(err), .count(error_count));
   etherneco_sat_counter #(.WIDTH(COUNT_WIDTH)) u_tmo_cnt (
      .clk(clk), .reset(reset), .clr(1'b0), .inc(tmo), .count(timeout_count));

   // Next-state, override policy and registered-output decode.
   always_comb begin
      state_d     = state_q;
      start_d     = 1'b0;
      ovr_d       = 1'b0;
      cor_d       = 1'b0;
      ovr_rem_d   = ovr_rem_q;
      ovr_cycle_d = ovr_cycle_q;
      synced_d    = synced_q;
      grant_go    = 1'b0;
      good        = 1'b0;
      err         = 1'b0;
      tmo         = 1'b0;
      case (state_q)
         IDLE:  if (enable) state_d = REQ;
         REQ: begin
            if (bus.ring_grant) begin
               state_d  = START;
               grant_go = 1'b1;
            end else if (!enable) begin
               state_d = IDLE;
            end
         end
         START: state_d = WAIT;
         WAIT: begin
            // A response on the timeout edge still counts as a response.
            if (bus.res_rx_end) begin
               if (bus.res_rx_error) err = 1'b1;
               else                  good = 1'b1;
               state_d = enable ? GAP : IDLE;
            end else if ((timeout != '0) && (tcnt >= timeout)) begin
               tmo     = 1'b1;
               state_d = enable ? GAP : IDLE;
            end
         end
         GAP: begin
            if (!enable)             state_d = IDLE;
            else if (icnt >= per_m1) state_d = REQ;
         end
         default: state_d = IDLE;
      endcase

      if (good) begin
         if (ovr_cycle_q && (ovr_rem_q != '0)) ovr_rem_d = ovr_rem_q - OW'(1);
         synced_d = (ovr_rem_d == '0);
      end
      if (err || tmo) begin
         ovr_rem_d = OVR_INIT;
         synced_d  = 1'b0;
      end
      // Resync applies last so it wins over a coincident good response.
      if (resync_req) begin
         ovr_rem_d = OVR_INIT;
         synced_d  = 1'b0;
      end
      if (grant_go) begin
         start_d     = 1'b1;
         ovr_d       = (ovr_rem_d != '0);
         cor_d       = (ovr_rem_d == '0);
         ovr_cycle_d = (ovr_rem_d != '0);
      end

      ring_req_d = (state_d == REQ) || (state_d == START) || (state_d == WAIT);
      busy_d     = (state_d != IDLE);
   end

   // FSM state and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         ring_req_q  <= 1'b0;
         start_q     <= 1'b0;
         ovr_q       <= 1'b0;
         cor_q       <= 1'b0;
         busy_q      <= 1'b0;
         synced_q    <= 1'b0;
         ovr_cycle_q <= 1'b0;
         ovr_rem_q   <= OVR_INIT;
      end else begin
         state_q     <= state_d;
         ring_req_q  <= ring_req_d;
         start_q     <= start_d;
         ovr_q       <= ovr_d;
         cor_q       <= cor_d;
         busy_q      <= busy_d;
         synced_q    <= synced_d;
         ovr_cycle_q <= ovr_cycle_d;
         ovr_rem_q   <= ovr_rem_d;
      end
   end

   assign bus.ring_req        = ring_req_q;
   assign bus.cmd_tx_start    = start_q;
   assign bus.cmd_tx_override = ovr_q;
   assign bus.cmd_tx_correct  = cor_q;
   assign busy                = busy_q;
   assign synced              = synced_q;
endmodule
